// File: rtl/mc_proc_controller_if.sv
// Handshake and strobe bundle between the multi-cycle controller and the
// instruction register, datapath, system registers and memory port.
interface mc_proc_controller_if #(
  parameter int NUM_IRQ = 4
);
  localparam int IRQW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  logic [7:0]         opcode;
  logic               mem_ready;
  logic               cond_true;
  logic [NUM_IRQ-1:0] irq;
  logic               ie;

  logic [7:0]         alu_ctrl;
  logic               alusrc;
  logic               ir_we;
  logic               pc_we;
  logic               reg_we;
  logic [1:0]         wb_sel;
  logic               mem_re;
  logic               mem_we;
  logic               branch_sel;
  logic               jump_sel;
  logic               sys_re;
  logic               sys_we;
  logic               sys_ret;
  logic               irq_take;
  logic [IRQW-1:0]    irq_id;
  logic               in_isr;

  modport master (
    output opcode, mem_ready, cond_true, irq, ie,
    input  alu_ctrl, alusrc, ir_we, pc_we, reg_we, wb_sel, mem_re, mem_we,
           branch_sel, jump_sel, sys_re, sys_we, sys_ret, irq_take, irq_id, in_isr
  );

  modport slave (
    input  opcode, mem_ready, cond_true, irq, ie,
    output alu_ctrl, alusrc, ir_we, pc_we, reg_we, wb_sel, mem_re, mem_we,
           branch_sel, jump_sel, sys_re, sys_we, sys_ret, irq_take, irq_id, in_isr
  );
endinterface

// File: rtl/mc_proc_controller.sv
// Multi-cycle processor controller: sequences each instruction through
// FETCH/DECODE/EXEC/MEM/WB and enters a single-cycle INTR at instruction boundaries.
//
// state  | meaning
// FETCH  | memory read of next instruction, wait for mem_ready
// DECODE | opcode settles, no strobes
// EXEC   | class-specific execute / branch / system access
// MEM    | LW read or SW write, wait for mem_ready
// WB     | register file write (ALU or memory result)
// INTR   | save PC, load vector, latch irq index, enter handler
module mc_proc_controller #(
  parameter int NUM_IRQ = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  mc_proc_controller_if.slave   bus
);
  localparam int IRQW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_INTR} state_t;
  typedef enum logic [2:0] {C_ALU, C_BCOND, C_JAL, C_LW, C_SW, C_RSR, C_WSR, C_RETI} cls_t;

  state_t          state_q, state_d, end_state;
  cls_t            cls;
  logic            imm;
  logic            in_isr_q, in_isr_d;
  logic [IRQW-1:0] irq_id_q, irq_id_d, irq_low;
  logic            reti_exec;

  always_comb begin
    cls = C_ALU;
    imm = 1'b0;
    if (bus.opcode[7:4] == 4'hF) begin
      if (bus.opcode[3:0] == 4'h2)      cls = C_RSR;
      else if (bus.opcode[3:0] == 4'h3) cls = C_WSR;
      else                              cls = C_RETI;
    end else if (bus.opcode[4]) begin
      imm = 1'b1;
      if (bus.opcode[5])      cls = C_JAL;
      else if (bus.opcode[6]) cls = C_SW;
      else                    cls = C_LW;
    end else if (bus.opcode[7]) begin
      imm = 1'b1;
    end else if (bus.opcode[6]) begin
      cls = C_BCOND;
    end
  end

  // Lowest asserted index wins; scan from the top so index 0 overrides.
  always_comb begin
    irq_low = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (bus.irq[i]) irq_low = IRQW'(i);
    end
  end

  // RETI drops in_isr in the same boundary decision, so a waiting request
  // is taken immediately after the return.
  assign reti_exec = (state_q == S_EXEC) && (cls == C_RETI);
  assign end_state = (bus.ie && (|bus.irq) && !(in_isr_q && !reti_exec)) ? S_INTR : S_FETCH;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_FETCH;
      in_isr_q <= 1'b0;
      irq_id_q <= '0;
    end else begin
      state_q  <= state_d;
      in_isr_q <= in_isr_d;
      irq_id_q <= irq_id_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    in_isr_d = in_isr_q;
    irq_id_d = irq_id_q;
    case (state_q)
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        case (cls)
          C_ALU:       state_d = S_WB;
          C_LW, C_SW:  state_d = S_MEM;
          default:     state_d = end_state;
        endcase
        if (cls == C_RETI) in_isr_d = 1'b0;
      end
      S_MEM: begin
        if (bus.mem_ready) state_d = (cls == C_LW) ? S_WB : end_state;
      end
      S_WB: state_d = end_state;
      S_INTR: begin
        state_d  = S_FETCH;
        in_isr_d = 1'b1;
        if (|bus.irq) irq_id_d = irq_low;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    bus.alu_ctrl   = 8'h00;
    bus.alusrc     = 1'b0;
    bus.ir_we      = 1'b0;
    bus.pc_we      = 1'b0;
    bus.reg_we     = 1'b0;
    bus.wb_sel     = 2'd0;
    bus.mem_re     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.branch_sel = 1'b0;
    bus.jump_sel   = 1'b0;
    bus.sys_re     = 1'b0;
    bus.sys_we     = 1'b0;
    bus.sys_ret    = 1'b0;
    bus.irq_take   = 1'b0;
    if (!reset_i) begin
      if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
        bus.alu_ctrl = bus.opcode;
        bus.alusrc   = imm;
      end
      case (state_q)
        S_FETCH: begin
          bus.mem_re = 1'b1;
          bus.ir_we  = bus.mem_ready;
          bus.pc_we  = bus.mem_ready;
        end
        S_EXEC: begin
          case (cls)
            C_BCOND: begin
              bus.branch_sel = 1'b1;
              bus.pc_we      = bus.cond_true;
            end
            C_JAL: begin
              bus.jump_sel = 1'b1;
              bus.pc_we    = 1'b1;
              bus.reg_we   = 1'b1;
              bus.wb_sel   = 2'd2;
            end
            C_RSR: begin
              bus.sys_re = 1'b1;
              bus.reg_we = 1'b1;
              bus.wb_sel = 2'd3;
            end
            C_WSR:  bus.sys_we = 1'b1;
            C_RETI: begin
              bus.sys_ret = 1'b1;
              bus.pc_we   = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          bus.mem_re = (cls == C_LW);
          bus.mem_we = (cls == C_SW);
        end
        S_WB: begin
          bus.reg_we = 1'b1;
          bus.wb_sel = (cls == C_LW) ? 2'd1 : 2'd0;
        end
        S_INTR: begin
          bus.irq_take = 1'b1;
          bus.sys_we   = 1'b1;
          bus.pc_we    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.irq_id = irq_id_q;
  assign bus.in_isr = in_isr_q;
endmodule

// File: tb/tb_mc_proc_controller.sv
// Directed bench for mc_proc_controller: the stimulus pushes the expected
// per-cycle output vector into a queue; a negedge monitor pops and compares.
module tb_mc_proc_controller;
  logic clk;
  logic reset;

  mc_proc_controller_if #(.NUM_IRQ(4)) bus ();

  mc_proc_controller #(.NUM_IRQ(4)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] alu;
    logic       alusrc, ir_we, pc_we, reg_we;
    logic [1:0] wb;
    logic       mem_re, mem_we, br, jmp, sys_re, sys_we, sys_ret, take;
    logic [1:0] id;
    logic       isr;
  } obs_t;

  localparam logic [11:0] SRC = 12'h800, IRW = 12'h400, PCW = 12'h200, RGW = 12'h100;
  localparam logic [11:0] MRE = 12'h080, MWE = 12'h040, BR  = 12'h020, JMP = 12'h010;
  localparam logic [11:0] SRE = 12'h008, SWE = 12'h004, RET = 12'h002, TAK = 12'h001;
  localparam obs_t CARE_ALL = obs_t'(25'h1FFFFFF);
  // During a reset cycle only the strobes are forced; irq_id/in_isr are still registered values.
  localparam obs_t CARE_STB = obs_t'(25'h1FFFFF8);

  obs_t  exp_q[$];
  obs_t  care_q[$];
  string nm_q[$];
  int    n_chk  = 0;
  int    n_pass = 0;
  logic       m_isr;
  logic [1:0] m_id;

  function automatic obs_t mk(input logic [7:0] a, input logic [11:0] f,
                              input logic [1:0] wb, input logic [1:0] id, input logic isr);
    obs_t o;
    o.alu = a;
    {o.alusrc, o.ir_we, o.pc_we, o.reg_we, o.mem_re, o.mem_we,
     o.br, o.jmp, o.sys_re, o.sys_we, o.sys_ret, o.take} = f;
    o.wb  = wb;
    o.id  = id;
    o.isr = isr;
    return o;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t  e, c, act;
      string n;
      e   = exp_q.pop_front();
      c   = care_q.pop_front();
      n   = nm_q.pop_front();
      act = mk(bus.alu_ctrl,
               {bus.alusrc, bus.ir_we, bus.pc_we, bus.reg_we, bus.mem_re, bus.mem_we,
                bus.branch_sel, bus.jump_sel, bus.sys_re, bus.sys_we, bus.sys_ret, bus.irq_take},
               bus.wb_sel, bus.irq_id, bus.in_isr);
      n_chk++;
      if (((act ^ e) & c) == '0) n_pass++;
      else $display("FAIL %s: got %07h want %07h (care %07h) at %0t", n, act, e, c, $time);
    end
  end

  task automatic cyc(input obs_t e, input obs_t c, input string nm);
    exp_q.push_back(e);
    care_q.push_back(c);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input logic [7:0] a, input logic [11:0] f, input logic [1:0] wb, input string nm);
    cyc(mk(a, f, wb, m_id, m_isr), CARE_ALL, nm);
  endtask

  task automatic fetch(input logic [7:0] op, input int waits);
    bus.opcode = op;
    for (int i = 0; i < waits; i++) begin
      bus.mem_ready = 1'b0;
      ex(8'h00, MRE, 2'd0, "fetch_wait");
    end
    bus.mem_ready = 1'b1;
    ex(8'h00, MRE | IRW | PCW, 2'd0, "fetch");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, %0d checks outstanding", exp_q.size());
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.opcode = 8'h00;
    bus.mem_ready = 1'b1;
    bus.cond_true = 1'b0;
    bus.irq = 4'b0000;
    bus.ie = 1'b0;
    m_isr = 1'b0;
    m_id = 2'd0;
    @(posedge clk);
    #1;
    cyc(mk(8'h00, 12'h000, 2'd0, 2'd0, 1'b0), CARE_STB, "reset");
    reset = 1'b0;

    // ALUR: FETCH, DECODE, EXEC, WB
    fetch(8'h00, 0);
    ex(8'h00, 12'h000, 2'd0, "alur_dec");
    ex(8'h00, 12'h000, 2'd0, "alur_exec");
    ex(8'h00, RGW, 2'd0, "alur_wb");

    fetch(8'h85, 0);
    ex(8'h85, SRC, 2'd0, "alui_dec");
    ex(8'h85, SRC, 2'd0, "alui_exec");
    ex(8'h85, SRC | RGW, 2'd0, "alui_wb");

    // LW with one fetch wait and three MEM waits
    fetch(8'h90, 1);
    ex(8'h90, SRC, 2'd0, "lw_dec");
    ex(8'h90, SRC, 2'd0, "lw_exec");
    bus.mem_ready = 1'b0;
    repeat (3) ex(8'h90, SRC | MRE, 2'd0, "lw_mem_wait");
    bus.mem_ready = 1'b1;
    ex(8'h90, SRC | MRE, 2'd0, "lw_mem");
    ex(8'h90, SRC | RGW, 2'd1, "lw_wb");

    fetch(8'hD0, 0);
    ex(8'hD0, SRC, 2'd0, "sw_dec");
    ex(8'hD0, SRC, 2'd0, "sw_exec");
    ex(8'hD0, SRC | MWE, 2'd0, "sw_mem");

    fetch(8'h40, 0);
    ex(8'h40, 12'h000, 2'd0, "bc_dec");
    bus.cond_true = 1'b0;
    ex(8'h40, BR, 2'd0, "bc_nt_exec");
    fetch(8'h40, 0);
    ex(8'h40, 12'h000, 2'd0, "bc_dec");
    bus.cond_true = 1'b1;
    ex(8'h40, BR | PCW, 2'd0, "bc_t_exec");
    bus.cond_true = 1'b0;

    fetch(8'h30, 0);
    ex(8'h30, SRC, 2'd0, "jal_dec");
    ex(8'h30, SRC | JMP | PCW | RGW, 2'd2, "jal_exec");

    fetch(8'hF2, 0);
    ex(8'hF2, 12'h000, 2'd0, "rsr_dec");
    ex(8'hF2, SRE | RGW, 2'd3, "rsr_exec");

    fetch(8'hF3, 0);
    ex(8'hF3, 12'h000, 2'd0, "wsr_dec");
    ex(8'hF3, SWE, 2'd0, "wsr_exec");

    // Interrupt on lines 1 and 3 during ALUR: line 1 wins
    fetch(8'h00, 0);
    ex(8'h00, 12'h000, 2'd0, "irq_alur_dec");
    ex(8'h00, 12'h000, 2'd0, "irq_alur_exec");
    bus.ie = 1'b1;
    bus.irq = 4'b1010;
    ex(8'h00, RGW, 2'd0, "irq_alur_wb");
    ex(8'h00, TAK | SWE | PCW, 2'd0, "intr1");
    m_isr = 1'b1;
    m_id = 2'd1;
    bus.irq = 4'b0100;

    // Handler: new request must wait for RETI
    fetch(8'h00, 0);
    ex(8'h00, 12'h000, 2'd0, "isr_alur_dec");
    ex(8'h00, 12'h000, 2'd0, "isr_alur_exec");
    ex(8'h00, RGW, 2'd0, "isr_alur_wb");
    fetch(8'hF0, 0);
    ex(8'hF0, 12'h000, 2'd0, "reti_dec");
    ex(8'hF0, RET | PCW, 2'd0, "reti_exec");
    m_isr = 1'b0;
    ex(8'h00, TAK | SWE | PCW, 2'd0, "intr2");
    m_isr = 1'b1;
    m_id = 2'd2;

    // Reset in the middle of an SW memory wait
    fetch(8'hD0, 0);
    ex(8'hD0, SRC, 2'd0, "sw2_dec");
    ex(8'hD0, SRC, 2'd0, "sw2_exec");
    bus.mem_ready = 1'b0;
    ex(8'hD0, SRC | MWE, 2'd0, "sw2_mem_wait");
    reset = 1'b1;
    cyc(mk(8'h00, 12'h000, 2'd0, 2'd0, 1'b0), CARE_STB, "reset_mid_mem");
    reset = 1'b0;
    bus.ie = 1'b0;
    bus.irq = 4'b0000;
    m_isr = 1'b0;
    m_id = 2'd0;
    fetch(8'h00, 0);
    ex(8'h00, 12'h000, 2'd0, "post_rst_dec");
    ex(8'h00, 12'h000, 2'd0, "post_rst_exec");
    ex(8'h00, RGW, 2'd0, "post_rst_wb");
    fetch(8'h00, 0);

    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending want 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mc_proc_controller.md
# mc_proc_controller

Multi-cycle successor to the single-cycle processor controller. It decodes the same 8-bit opcode classes into datapath strobes. Each instruction is sequenced through FETCH/DECODE/EXEC/MEM/WB states, with a ready/handshake on memory and NUM_IRQ prioritised interrupt lines. The block sits between the instruction register and the datapath muxes, register file, system registers and memory port.

## Interface
- NUM_IRQ, 4: number of interrupt request lines (1..16); line 0 has the highest priority.
- IRQW, $clog2(NUM_IRQ) (min 1): width of irq_id.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  8  current instruction opcode (instruction register output; valid from DECODE onward).
- mem_ready  in  1  memory completion handshake; sampled only in FETCH and MEM.
- cond_true  in  1  branch condition result from the datapath; sampled only in EXEC of BCOND.
- irq  in  NUM_IRQ  level-sensitive interrupt requests.
- ie  in  1  global interrupt enable (system register bit).
- alu_ctrl  out  8  equals opcode in DECODE/EXEC/MEM/WB; 0 otherwise.
- alusrc  out  1  1 = immediate operand (ALUI, CMPI, LW, SW, JAL).
- ir_we, pc_we  out  1 each  instruction register / PC load strobes.
- reg_we  out  1  register file write enable.
- wb_sel  out  2  writeback source: 0 ALU, 1 memory, 2 PC+4, 3 system register.
- mem_re, mem_we  out  1 each  memory read / write request.
- branch_sel, jump_sel  out  1 each  PC source = branch target / ALU result.
- sys_re, sys_we, sys_ret  out  1 each  RSR read, WSR write, RETI return.
- irq_take  out  1  interrupt entry strobe (PC saved, vector loaded).
- irq_id  out  IRQW  registered index of the interrupt taken.
- in_isr  out  1  handler in progress; blocks nesting.

## Operation
- Decode, first match wins:
  - opcode[7:4]=F: SYS; [3:0]=2 RSR, =3 WSR, otherwise RETI.
  - Otherwise opcode[4]=1: opcode[5] JAL, else opcode[6] SW, else LW.
  - Otherwise opcode[7] ALUI/CMPI.
  - Otherwise opcode[6] BCOND.
  - Otherwise ALUR/CMPR.
- States: FETCH, DECODE, EXEC, MEM, WB, INTR. Reset state is FETCH.
- FETCH: mem_re=1, held until mem_ready. The cycle mem_ready=1: ir_we=1, pc_we=1 (PC+4), next state DECODE.
- DECODE: no strobes; next state EXEC.
- EXEC, by class:
  - ALUR/ALUI/CMP: next WB.
  - BCOND: branch_sel=1, pc_we=cond_true; next END.
  - JAL: jump_sel=1, pc_we=1, reg_we=1, wb_sel=2; next END.
  - LW/SW: address compute; next MEM.
  - RSR: sys_re=1, reg_we=1, wb_sel=3; next END.
  - WSR: sys_we=1; next END.
  - RETI: sys_ret=1, pc_we=1, in_isr cleared; next END.
- MEM: LW holds mem_re, SW holds mem_we, until mem_ready. Then LW goes to WB, SW goes to END.
- WB: reg_we=1; wb_sel=1 for LW, 0 otherwise; next END.
- END (the instruction-boundary decision, not a state): if ie && |irq && !in_isr, go to INTR; else go to FETCH.
- INTR, single cycle:
  - irq_take=1, sys_we=1 (save PC), pc_we=1 (vector).
  - irq_id <= lowest asserted index.
  - in_isr <= 1.
  - Next state FETCH.
- Requests deasserted before the END decision are lost. Requests arriving while in_isr=1 are taken at the first instruction boundary after RETI.

## Timing
- All strobes are Moore outputs of the registered state (plus opcode/cond_true), forced to 0 while reset=1.
- After reset deasserts, the first cycle is FETCH with mem_re=1. irq_id, in_isr and state all reset to 0/FETCH.
- Reset in any state (including mid-MEM or INTR) returns the block to FETCH next cycle and clears in_isr; any pending memory request is dropped.
- Minimum latency with mem_ready tied 1:
  - BCOND/JAL/RSR/WSR/RETI: 3 cycles.
  - ALU: 4 cycles.
  - SW: 4 cycles.
  - LW: 5 cycles.
  - INTR: adds 1 cycle.
- Each wait cycle with mem_ready=0 in FETCH/MEM adds exactly 1 cycle. Request strobes stay stable during the wait.
- irq, ie and mem_ready are assumed synchronous to clk.

## Test plan
- Reset, mem_ready=1, opcode=0x00 (ALUR) → DECODE at cycle 2, WB at cycle 4 with reg_we=1, wb_sel=0; FETCH again at cycle 5.
- LW (0x90) with mem_ready low 3 cycles in MEM → mem_re held 4 cycles, then WB with wb_sel=1, reg_we=1; total 8 cycles.
- BCOND (0x40): cond_true=0 → pc_we=0 in EXEC; cond_true=1 → pc_we=1 and branch_sel=1.
- ie=1, irq=4'b1010 during ALUR → INTR after WB with irq_take=1 and irq_id=1. A second irq during the handler is ignored until RETI (0xF0) clears in_isr, then taken.
- RSR (0xF2) → sys_re=1, reg_we=1, wb_sel=3 in EXEC. WSR (0xF3) → sys_we=1 only.
- Reset asserted mid-MEM of SW (0xD0) → all strobes 0 that cycle, FETCH next cycle, in_isr=0, no mem_we afterwards.
